// File: rtl/cape_gpio_ctrl.sv
// APB3 GPIO controller for cape header pins: output/direction registers, synchronised
// input with edge-detect interrupt. Optional input debounce via `CAPE_GPIO_DEBOUNCE_EN.
module cape_gpio_ctrl #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [4:0]       PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    output logic [WIDTH-1:0] GPIO_OUT,
    output logic [WIDTH-1:0] GPIO_OE,
    input  logic [WIDTH-1:0] GPIO_IN,
    output logic             IRQ
);

    typedef enum logic [2:0] {
        A_DATA_OUT = 3'd0,
        A_DIR      = 3'd1,
        A_DATA_IN  = 3'd2,
        A_RISE_EN  = 3'd3,
        A_FALL_EN  = 3'd4,
        A_IRQ_STAT = 3'd5
    } reg_idx_e;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_stat;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_prev;
    logic             r_irq;

    logic [2:0]       w_idx;
    logic             w_access;
    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_unused;

    assign w_idx    = PADDR[4:2];
    assign w_access = PSEL & PENABLE;
    assign w_wr     = w_access & PWRITE;
    assign w_wdata  = PWDATA[WIDTH-1:0];
    assign w_unused = ^{PADDR[1:0], PWDATA};

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_data_out <= '0;
            r_dir      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
        end else if (w_wr) begin
            case (w_idx)
                A_DATA_OUT: r_data_out <= w_wdata;
                A_DIR:      r_dir      <= w_wdata;
                A_RISE_EN:  r_rise_en  <= w_wdata;
                A_FALL_EN:  r_fall_en  <= w_wdata;
                default:    ;
            endcase
        end
    end

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (w_access) begin
            case (w_idx)
                A_DATA_OUT: PRDATA[WIDTH-1:0] = r_data_out;
                A_DIR:      PRDATA[WIDTH-1:0] = r_dir;
                A_DATA_IN:  PRDATA[WIDTH-1:0] = r_filt;
                A_RISE_EN:  PRDATA[WIDTH-1:0] = r_rise_en;
                A_FALL_EN:  PRDATA[WIDTH-1:0] = r_fall_en;
                A_IRQ_STAT: PRDATA[WIDTH-1:0] = r_irq_stat;
                default:    PSLVERR = 1'b1;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= GPIO_IN;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CAPE_GPIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_sync_prev;

    // A pin's counter only advances while its synchronised level is steady and differs from f.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_cnt       <= '{default: '0};
            r_filt      <= '0;
            r_sync_prev <= '0;
        end else begin
            r_sync_prev <= r_sync2;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((r_sync2[i] == r_filt[i]) || (r_sync2[i] != r_sync_prev[i])) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else if (r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_filt <= '0;
        end else begin
            r_filt <= r_sync2;
        end
    end
`endif

    assign w_rise = r_filt & ~r_filt_prev;
    assign w_fall = ~r_filt & r_filt_prev;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (w_wr && (w_idx == A_IRQ_STAT)) ? w_wdata : '0;

    // Set is OR-ed in after the clear so a same-cycle event survives a W1C.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_filt_prev <= '0;
            r_irq_stat  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_filt_prev <= r_filt;
            r_irq_stat  <= (r_irq_stat & ~w_clr) | w_set;
            r_irq       <= |r_irq_stat;
        end
    end

    assign GPIO_OUT = r_data_out;
    assign GPIO_OE  = r_dir;
    assign IRQ      = r_irq;
    assign PREADY   = 1'b1;

endmodule

// File: tb/tb_cape_gpio_ctrl.sv
// Directed self-checking bench for cape_gpio_ctrl; debounce steps are built when
// CAPE_GPIO_DEBOUNCE_EN is defined, edge/latency steps otherwise.
module tb_cape_gpio_ctrl;

    localparam int unsigned W = 2;

    logic          PCLK    = 1'b0;
    logic          PRESETN = 1'b0;
    logic          PSEL    = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE  = 1'b0;
    logic [4:0]    PADDR   = '0;
    logic [31:0]   PWDATA  = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [W-1:0]  GPIO_OUT;
    logic [W-1:0]  GPIO_OE;
    logic [W-1:0]  GPIO_IN = '0;
    logic          IRQ;

    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    logic [31:0] d;
    logic        e;

    cape_gpio_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_OUT(GPIO_OUT),
        .GPIO_OE(GPIO_OE), .GPIO_IN(GPIO_IN), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered just after a falling edge.
    task automatic apb_write(input logic [4:0] a, input logic [31:0] wd);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = wd; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] rd, output logic err);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rd  = PRDATA;
        err = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Zero-cycle look at the combinational read path, used for cycle-exact timing checks.
    task automatic peek(input logic [4:0] a, output logic [31:0] rd);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
        #1;
        rd = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb_read(a, rd, err);
        chk(tag, rd, exp);
        chk({tag, "_slverr"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        chk("rst_oe",  {30'd0, GPIO_OE},  32'd0);
        chk("rst_out", {30'd0, GPIO_OUT}, 32'd0);
        chk("rst_irq", {31'd0, IRQ},      32'd0);
        PRESETN = 1'b1;
        @(negedge PCLK);
        chk("pready", {31'd0, PREADY}, 32'd1);
        for (int i = 0; i < 6; i++) rd_chk($sformatf("rst_reg%0d", i), 5'(i * 4), 32'd0);

        apb_write(5'h04, 32'h0000_0003);
        chk("oe_after_wr", {30'd0, GPIO_OE}, 32'd3);
        apb_write(5'h00, 32'hFFFF_FFF2);
        chk("out_after_wr", {30'd0, GPIO_OUT}, 32'd2);
        rd_chk("rb_data_out", 5'h00, 32'd2);
        rd_chk("rb_dir",      5'h04, 32'd3);
        PADDR = 5'h00;
        #1;
        chk("prdata_unsel", PRDATA, 32'd0);

        apb_read(5'h18, d, e);
        chk("unm18_rd", d, 32'd0);
        chk("unm18_err", {31'd0, e}, 32'd1);
        apb_read(5'h1C, d, e);
        chk("unm1c_err", {31'd0, e}, 32'd1);
        apb_write(5'h18, 32'hFFFF_FFFF);
        apb_write(5'h1C, 32'hFFFF_FFFF);
        apb_write(5'h08, 32'hFFFF_FFFF);
        rd_chk("unm_data_out", 5'h00, 32'd2);
        rd_chk("unm_dir",      5'h04, 32'd3);
        rd_chk("unm_data_in",  5'h08, 32'd0);
        rd_chk("unm_rise_en",  5'h0C, 32'd0);
        rd_chk("unm_fall_en",  5'h10, 32'd0);
        rd_chk("unm_irq_stat", 5'h14, 32'd0);

`ifndef CAPE_GPIO_DEBOUNCE_EN
        apb_write(5'h0C, 32'd1);
        GPIO_IN = 2'b01;
        @(negedge PCLK);
        @(negedge PCLK);
        peek(5'h08, d); chk("din_lat2", d, 32'd0);
        @(negedge PCLK);
        peek(5'h08, d); chk("din_lat3", d, 32'd1);
        peek(5'h14, d); chk("stat_lat3", d, 32'd0);
        @(negedge PCLK);
        peek(5'h14, d); chk("stat_lat4", d, 32'd1);
        chk("irq_lat4", {31'd0, IRQ}, 32'd0);
        @(negedge PCLK);
        chk("irq_lat5", {31'd0, IRQ}, 32'd1);

        apb_write(5'h14, 32'd1);
        peek(5'h14, d); chk("w1c_stat", d, 32'd0);
        @(negedge PCLK);
        chk("w1c_irq", {31'd0, IRQ}, 32'd0);

        apb_write(5'h10, 32'd2);
        GPIO_IN = 2'b11;
        repeat (6) @(negedge PCLK);
        peek(5'h14, d); chk("rise1_masked", d, 32'd0);
        chk("rise1_irq", {31'd0, IRQ}, 32'd0);
        GPIO_IN = 2'b01;
        @(negedge PCLK);
        @(negedge PCLK);
        apb_write(5'h14, 32'd2);
        peek(5'h14, d); chk("set_beats_clr", d, 32'd2);
        @(negedge PCLK);
        chk("set_beats_clr_irq", {31'd0, IRQ}, 32'd1);
        apb_write(5'h14, 32'd0);
        peek(5'h14, d); chk("w0_no_effect", d, 32'd2);
        apb_write(5'h10, 32'd0);
        peek(5'h14, d); chk("dis_keeps_stat", d, 32'd2);
        apb_write(5'h14, 32'd2);
        @(negedge PCLK);
        peek(5'h14, d); chk("final_stat", d, 32'd0);
        chk("final_irq", {31'd0, IRQ}, 32'd0);
`else
        apb_write(5'h0C, 32'd1);
        GPIO_IN = 2'b01;
        repeat (10) @(negedge PCLK);
        GPIO_IN = 2'b00;
        repeat (30) @(negedge PCLK);
        peek(5'h08, d); chk("pulse_din", d, 32'd0);
        peek(5'h14, d); chk("pulse_stat", d, 32'd0);
        chk("pulse_irq", {31'd0, IRQ}, 32'd0);

        GPIO_IN = 2'b01;
        repeat (16) @(negedge PCLK);
        peek(5'h08, d); chk("lvl_din_early", d, 32'd0);
        repeat (24) @(negedge PCLK);
        peek(5'h08, d); chk("lvl_din", d, 32'd1);
        peek(5'h14, d); chk("lvl_stat", d, 32'd1);
        chk("lvl_irq", {31'd0, IRQ}, 32'd1);

        apb_write(5'h14, 32'd1);
        @(negedge PCLK);
        chk("db_w1c_irq", {31'd0, IRQ}, 32'd0);
        GPIO_IN = 2'b00;
        repeat (40) @(negedge PCLK);
        peek(5'h08, d); chk("db_fall_din", d, 32'd0);
        GPIO_IN = 2'b01;
        repeat (10) @(negedge PCLK);
        PRESETN = 1'b0;
        @(negedge PCLK);
        chk("midrst_irq", {31'd0, IRQ},     32'd0);
        chk("midrst_oe",  {30'd0, GPIO_OE}, 32'd0);
        PRESETN = 1'b1;
        @(negedge PCLK);
        for (int i = 0; i < 6; i++) rd_chk($sformatf("midrst_reg%0d", i), 5'(i * 4), 32'd0);
        repeat (40) @(negedge PCLK);
        chk("post_rst_irq", {31'd0, IRQ}, 32'd0);
        peek(5'h14, d); chk("post_rst_stat", d, 32'd0);
        peek(5'h08, d); chk("post_rst_din", d, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
